cache_control: RTL

//  Control FSM for the 2-way set-associative LC-3b cache: one line 128b, 8 words.

---
 rtl/cache_control_pkg.sv | 27 ++
 rtl/cache_control_if.sv | 29 ++
 rtl/cache_control_perf_counters.sv | 31 +++
 rtl/cache_control.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cache_control_pkg.sv
// Shared types and helpers for the 2-way set-associative LC-3b cache controller.
// Covers the controller states, the way select and per-way enables, and the victim choice.
package cache_control_pkg;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

  typedef logic       lc3b_way;
  typedef logic [1:0] lc3b_way_en;
  typedef logic [1:0] lc3b_mem_wmask;

  function automatic lc3b_way_en way_en(input lc3b_way way);
    way_en = way ? 2'b10 : 2'b01;
  endfunction

  // An empty way is always filled before anything valid is evicted.
  function automatic lc3b_way pick_victim(input logic valid0, input logic valid1,
                                          input lc3b_way lru);
    if (!valid0)      pick_victim = 1'b0;
    else if (!valid1) pick_victim = 1'b1;
    else              pick_victim = lru;
  endfunction

endpackage

// File: rtl/cache_control_if.sv
// CPU-side request port and physical-memory port of the cache controller.
// The master drives requests and pmem_resp. The slave is the controller.
interface cache_control_if;
  import cache_control_pkg::*;

  // Handshake: mem_read/mem_write act as valid and stay high until the
  // one-cycle mem_resp pulse, which completes the request. pmem_read and
  // pmem_write act as valid and stay high until the one-cycle pmem_resp.
  // The two pmem requests are never high together.
  logic          mem_read;
  logic          mem_write;
  lc3b_mem_wmask mem_byte_enable;
  logic          mem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic          pmem_resp;
  logic          pmem_addr_sel;

  modport master (
    output mem_read, mem_write, mem_byte_enable, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_addr_sel
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_addr_sel
  );

endinterface

// File: rtl/cache_control_perf_counters.sv
// Saturating hit, miss and write-back event counters for the cache controller.
// The top level instantiates this block only when CACHE_PERF_CNT_EN is defined.
module cache_perf_counters #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hit_ev,
  input  logic                 miss_ev,
  input  logic                 wb_ev,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt,
  output logic [CNT_WIDTH-1:0] wb_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (hit_ev && (hit_cnt != CNT_MAX))   hit_cnt  <= hit_cnt + CNT_ONE;
      if (miss_ev && (miss_cnt != CNT_MAX)) miss_cnt <= miss_cnt + CNT_ONE;
      if (wb_ev && (wb_cnt != CNT_MAX))     wb_cnt   <= wb_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/cache_control.sv
// Control FSM of the 2-way set-associative LC-3b cache: hit handling, write-back and line allocate.
// Optional feature macro: CACHE_PERF_CNT_EN adds saturating hit_cnt/miss_cnt/wb_cnt outputs.
module cache_control
  import cache_control_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_control_if.slave       bus,
  input  logic                 hit0,
  input  logic                 hit1,
  input  logic                 valid0,
  input  logic                 valid1,
  input  logic                 dirty0,
  input  logic                 dirty1,
  input  lc3b_way              lru_out,
  output lc3b_way              way_sel,
  output logic                 datain_sel,
  output lc3b_way_en           data_write,
  output lc3b_way_en           tag_write,
  output lc3b_way_en           valid_write,
  output lc3b_way_en           dirty_write,
  output logic                 dirty_in,
  output logic                 lru_write,
  output lc3b_way              lru_in,
  output cache_state_t         state_dbg
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt,
  output logic [CNT_WIDTH-1:0] wb_cnt
`endif
);

  cache_state_t state;
  cache_state_t state_next;
  logic         req;
  logic         is_write;
  logic         hit;
  lc3b_way      hitway;
  lc3b_way      victim;
  logic         victim_dirty;

  // A simultaneous read and write request is handled as a write.
  assign req          = bus.mem_read | bus.mem_write;
  assign is_write     = bus.mem_write;
  assign hit          = (hit0 & valid0) | (hit1 & valid1);
  assign hitway       = hit1 & valid1;
  assign victim       = pick_victim(valid0, valid1, lru_out);
  assign victim_dirty = victim ? (dirty1 & valid1) : (dirty0 & valid0);
  assign state_dbg    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CHECK;
    else        state <= state_next;
  end

  always_comb begin
    state_next        = state;
    bus.mem_resp      = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    way_sel           = 1'b0;
    datain_sel        = 1'b0;
    data_write        = 2'b00;
    tag_write         = 2'b00;
    valid_write       = 2'b00;
    dirty_write       = 2'b00;
    dirty_in          = 1'b0;
    lru_write         = 1'b0;
    lru_in            = 1'b0;

    unique case (state)
      CHECK: begin
        if (req && hit) begin
          bus.mem_resp = 1'b1;
          way_sel      = hitway;
          lru_write    = 1'b1;
          lru_in       = ~hitway;
          if (is_write && (bus.mem_byte_enable != 2'b00)) begin
            datain_sel  = 1'b1;
            data_write  = way_en(hitway);
            dirty_write = way_en(hitway);
            dirty_in    = 1'b1;
          end
        end else if (req) begin
          state_next = victim_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.pmem_write    = 1'b1;
        bus.pmem_addr_sel = 1'b1;
        way_sel           = victim;
        if (bus.pmem_resp) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        bus.pmem_read = 1'b1;
        way_sel       = victim;
        // The incoming line lands clean. A pending CPU write is merged by the re-check hit.
        if (bus.pmem_resp) begin
          data_write  = way_en(victim);
          tag_write   = way_en(victim);
          valid_write = way_en(victim);
          dirty_write = way_en(victim);
          state_next  = CHECK;
        end
      end
      default: state_next = CHECK;
    endcase

    // Reset is asynchronous, so every output has to drop with it, not at the next edge.
    if (!rst_n) begin
      bus.mem_resp      = 1'b0;
      bus.pmem_read     = 1'b0;
      bus.pmem_write    = 1'b0;
      bus.pmem_addr_sel = 1'b0;
      way_sel           = 1'b0;
      datain_sel        = 1'b0;
      data_write        = 2'b00;
      tag_write         = 2'b00;
      valid_write       = 2'b00;
      dirty_write       = 2'b00;
      dirty_in          = 1'b0;
      lru_write         = 1'b0;
      lru_in            = 1'b0;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic refill_q;
  logic hit_ev;
  logic miss_ev;
  logic wb_ev;

  // The first CHECK cycle after a fill is the re-check of the missed request.
  // That cycle is not counted as a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) refill_q <= 1'b0;
    else        refill_q <= (state == ALLOCATE) && bus.pmem_resp;
  end

  assign hit_ev  = (state == CHECK) && bus.mem_resp && !refill_q;
  assign miss_ev = (state == CHECK) && req && !hit;
  assign wb_ev   = (state == CHECK) && (state_next == WRITEBACK);

  cache_perf_counters #(.CNT_WIDTH(CNT_WIDTH)) u_perf (
    .clk      (clk),
    .rst_n    (rst_n),
    .hit_ev   (hit_ev),
    .miss_ev  (miss_ev),
    .wb_ev    (wb_ev),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
  );
`else
  // CNT_WIDTH only sizes the perf counters, which are not built here.
  if (CNT_WIDTH < 1) begin : g_cnt_width_unused
  end
`endif

endmodule
